// File: rtl/wash_cycle_timer.sv
// Wash/rinse and spin period timer with level timeout handshakes and a remaining-tick count.
// Optional pause support is enabled by defining WASH_TIMER_PAUSE_EN.
module wash_cycle_timer #(
    parameter int unsigned PRESCALE    = 1000,
    parameter int unsigned SOAP_TICKS  = 600,
    parameter int unsigned RINSE_TICKS = 300,
    parameter int unsigned SPIN_TICKS  = 200,
    parameter int unsigned W           = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cycle_run,
    input  logic         spin_run,
    input  logic         rinse,
    input  logic         pause,
    output logic         cycle_timeout,
    output logic         spin_timeout,
    output logic         busy,
    output logic [W-1:0] remaining
);

    localparam int unsigned      PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN_CYCLE,
        CYCLE_DONE,
        RUN_SPIN,
        SPIN_DONE
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [W-1:0]  remaining_nx;
    logic          busy_nx, cycle_timeout_nx, spin_timeout_nx;
    logic          hold;
    logic          run_req;
    logic          tick;

`ifdef WASH_TIMER_PAUSE_EN
    assign hold = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign hold         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            presc         <= '0;
            remaining     <= '0;
            busy          <= 1'b0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
        end else begin
            state         <= state_nx;
            presc         <= presc_nx;
            remaining     <= remaining_nx;
            busy          <= busy_nx;
            cycle_timeout <= cycle_timeout_nx;
            spin_timeout  <= spin_timeout_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        presc_nx     = presc;
        remaining_nx = remaining;
        run_req      = (state == RUN_SPIN || state == SPIN_DONE) ? spin_run : cycle_run;
        tick         = (presc == PRESC_LAST);

        case (state)
            IDLE: begin
                // Spin wins when both requests arrive together
                if (spin_run) begin
                    state_nx     = RUN_SPIN;
                    remaining_nx = W'(SPIN_TICKS);
                    presc_nx     = '0;
                end else if (cycle_run) begin
                    state_nx     = RUN_CYCLE;
                    remaining_nx = rinse ? W'(RINSE_TICKS) : W'(SOAP_TICKS);
                    presc_nx     = '0;
                end
            end
            RUN_CYCLE, RUN_SPIN: begin
                if (!run_req) begin
                    state_nx     = IDLE;
                    remaining_nx = '0;
                    presc_nx     = '0;
                end else if (!hold) begin
                    if (tick) begin
                        presc_nx = '0;
                        if (remaining <= W'(1)) begin
                            remaining_nx = '0;
                            state_nx     = (state == RUN_SPIN) ? SPIN_DONE : CYCLE_DONE;
                        end else begin
                            remaining_nx = remaining - 1'b1;
                        end
                    end else begin
                        presc_nx = presc + 1'b1;
                    end
                end
            end
            CYCLE_DONE, SPIN_DONE: begin
                if (!run_req) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx     = IDLE;
                remaining_nx = '0;
                presc_nx     = '0;
            end
        endcase

        // Outputs are registered copies of what the next state implies
        busy_nx          = (state_nx == RUN_CYCLE) || (state_nx == RUN_SPIN);
        cycle_timeout_nx = (state_nx == CYCLE_DONE);
        spin_timeout_nx  = (state_nx == SPIN_DONE);
    end

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Randomized and directed bench for wash_cycle_timer against an elapsed-time reference model.
module tb_wash_cycle_timer;

    localparam int unsigned P  = 4;
    localparam int unsigned SO = 3;
    localparam int unsigned RI = 2;
    localparam int unsigned SP = 5;
    localparam int unsigned W  = 8;

`ifdef WASH_TIMER_PAUSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         cycle_run, spin_run, rinse, pause;
    logic         cycle_timeout, spin_timeout, busy;
    logic [W-1:0] remaining;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 running, 2 done; kind 0 cycle, 1 spin
    int m_phase, m_kind, m_ticks, m_elapsed;

    always #5 clk = ~clk;

    wash_cycle_timer #(
        .PRESCALE   (P),
        .SOAP_TICKS (SO),
        .RINSE_TICKS(RI),
        .SPIN_TICKS (SP),
        .W          (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cycle_run    (cycle_run),
        .spin_run     (spin_run),
        .rinse        (rinse),
        .pause        (pause),
        .cycle_timeout(cycle_timeout),
        .spin_timeout (spin_timeout),
        .busy         (busy),
        .remaining    (remaining)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase   = 0;
        m_kind    = 0;
        m_ticks   = 0;
        m_elapsed = 0;
    endfunction

    function automatic bit model_req();
        return (m_kind == 1) ? spin_run : cycle_run;
    endfunction

    function automatic void model_step();
        if (!reset) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (spin_run) begin
                m_phase = 1; m_kind = 1; m_ticks = SP; m_elapsed = 0;
            end else if (cycle_run) begin
                m_phase = 1; m_kind = 0; m_ticks = rinse ? RI : SO; m_elapsed = 0;
            end
        end else if (m_phase == 1) begin
            if (!model_req()) begin
                m_phase = 0;
            end else if (!(PEN && pause)) begin
                m_elapsed++;
                if (m_elapsed == m_ticks * P) m_phase = 2;
            end
        end else begin
            if (!model_req()) m_phase = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        int unsigned exp_rem;
        exp_rem = (m_phase == 1) ? m_ticks - m_elapsed / P : 0;
        check({tag, ".busy"}, busy, (m_phase == 1) ? 1 : 0);
        check({tag, ".remaining"}, remaining, exp_rem);
        check({tag, ".cycle_timeout"}, cycle_timeout, (m_phase == 2 && m_kind == 0) ? 1 : 0);
        check({tag, ".spin_timeout"}, spin_timeout, (m_phase == 2 && m_kind == 1) ? 1 : 0);
    endtask

    // One clock: model follows the inputs sampled at the edge; returns at the next negedge
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic wait_timeout(input string tag, input int exp_lat);
        int n = 0;
        while (n < 200) begin
            step(tag);
            n++;
            if (cycle_timeout || spin_timeout) break;
        end
        check({tag, ".latency"}, n, exp_lat);
    endtask

    task automatic go_idle();
        cycle_run = 0; spin_run = 0; pause = 0;
        repeat (2) step("idle");
    endtask

    initial begin
        reset = 0; cycle_run = 0; spin_run = 0; rinse = 0; pause = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1;
        step("post_reset");

        // Soap cycle: remaining 3,2,1 then timeout at E0+12, falls one clock after drop
        cycle_run = 1; rinse = 0;
        step("soap_e0");
        check("soap.rem_e0", remaining, 3);
        wait_timeout("soap", 12);
        cycle_run = 0;
        step("soap_drop");
        check("soap.timeout_fall", cycle_timeout, 0);

        // Rinse then spin
        cycle_run = 1; rinse = 1;
        step("rinse_e0");
        rinse = 0;
        wait_timeout("rinse", 8);
        cycle_run = 0;
        spin_run = 1;
        step("rinse_drop");
        step("spin_e0");
        check("spin.rem_e0", remaining, 5);
        wait_timeout("spin", 20);
        go_idle();

        // Abort at E0+6 and restart
        cycle_run = 1; rinse = 0;
        repeat (6) step("abort_run");
        cycle_run = 0;
        step("abort_drop");
        check("abort.busy", busy, 0);
        check("abort.remaining", remaining, 0);
        cycle_run = 1;
        step("restart_e0");
        wait_timeout("restart", 12);
        go_idle();

        // Simultaneous requests
        cycle_run = 1; spin_run = 1;
        step("simul_e0");
        check("simul.remaining", remaining, 5);
        wait_timeout("simul", 20);
        go_idle();

        // Pause for 7 clocks mid-soap
        cycle_run = 1; rinse = 0;
        step("pause_e0");
        repeat (3) step("pause_pre");
        pause = 1;
        repeat (7) step("pause_hold");
        pause = 0;
        wait_timeout("pause", (PEN ? 19 : 12) - 10);
        go_idle();

        // Reset mid-count
        cycle_run = 1;
        repeat (5) step("rst_run");
        reset = 0;
        #1;
        model_reset();
        check_all("rst_async");
        step("rst_low");
        reset = 1;
        step("rst_e0");
        wait_timeout("rst_restart", 12);
        go_idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_phase == 2 && ($urandom % 2 == 0)) begin
                if (m_kind == 0) cycle_run = 0; else spin_run = 0;
            end else begin
                if ($urandom % 20 == 0) cycle_run = ~cycle_run;
                if ($urandom % 30 == 0) spin_run = ~spin_run;
            end
            rinse = $urandom % 2;
            pause = ($urandom % 4 == 0);
            if ($urandom % 400 == 0) begin
                reset = 0;
                #1;
                model_reset();
                check_all("rand_async_rst");
                step("rand_rst_low");
                reset = 1;
            end else begin
                step("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
